note_octave_folder: RTL and testbench
=====================================

// Module: note_octave_folder
// PURPOSE
//  Producer side of the amplitude-preprocessor interface. Takes a serial stream of
//  per-bin DFT magnitudes (OCTAVES*BIN_QTY bins per frame, ordered octave-major), folds
//  octaves into BIN_QTY note amplitudes and presents them as noteAmplitudes_o with a
//  start_o request. Holds start_o until the preprocessor returns data_v_i, then
//  accepts the next frame. Sits between the DFT magnitude stage and AmpPreprocessor.
// PARAMETERS
//  W        5   whole bits of unsigned fixed-point amplitude
//  D        11  fractional bits (1.0 = 1<<D)
//  BIN_QTY  12  notes per octave
//  OCTAVES  5   octaves folded per frame; frame = OCTAVES*BIN_QTY input bins
// PORTS
//  clk               in   1                   clock; all logic on rising edge
//  rst               in   1                   synchronous reset, active-low (0 = reset)
//  bin_i             in   W+D                 unsigned bin magnitude
//  bin_v_i           in   1                   bin_i valid
//  bin_rdy_o         out  1                   ready; bin accepted when bin_v_i & bin_rdy_o
//  flush_i           in   1                   discard partial frame, restart at bin 0
//  noteAmplitudes_o  out  [BIN_QTY][W+D]      folded note amplitudes, to noteAmplitudes_i
//  start_o           out  1                   request to preprocessor, to start
//  data_v_i          in   1                   preprocessor done, from data_v
//  frame_cnt_o       out  8                   completed handoffs, wraps 255->0
// BEHAVIOUR
//  Reset (rst=0 at an edge): state=ACCUM, note/octave counters=0, all accumulators=0,
//   noteAmplitudes_o=0, start_o=0, frame_cnt_o=0. bin_rdy_o=0 while rst=0.
//  bin_rdy_o = (state==ACCUM) & rst; combinational from state.
//  FSM: ACCUM -> XFER -> WAIT -> ACCUM.
//   ACCUM: on accept, acc[note] <= (octave==0 ? bin_i : acc[note]+bin_i); note++;
//    note wraps BIN_QTY-1 -> 0 with octave++. Accept of note=BIN_QTY-1,
//    octave=OCTAVES-1 -> counters to 0, state XFER.
//   XFER (1 cycle): noteAmplitudes_o[n] <= sat(acc[n]); start_o <= 1; state WAIT.
//    start_o is first high 2 edges after the edge accepting the last bin.
//   WAIT: start_o held 1; noteAmplitudes_o stable. data_v_i ignored until start_o has
//    been high for >=2 cycles (stale done from prior frame). Qualifying data_v_i=1 ->
//    next edge: start_o<=0, frame_cnt_o++, state ACCUM (bin_rdy_o high that cycle).
//  noteAmplitudes_o changes only in XFER; stable through WAIT and next ACCUM.
//  Arithmetic: acc width W+D+$clog2(OCTAVES); sat(x) = all-ones (W+D bits) if any bit
//   above W+D-1 set, else x[W+D-1:0]. No rounding, no wrap.
//  flush_i: in ACCUM, next edge counters<=0 (acc overwritten by octave-0 rule); a bin
//   accepted the same cycle is discarded. Ignored in XFER/WAIT.
//  bin_v_i outside ACCUM: no accept, counters frozen, bin_i ignored.
//  Reset mid-frame or in WAIT: immediate return to reset state; start_o drops next edge.
// TESTING
//  1 rst=0 for 3 cycles -> start_o=0, bin_rdy_o=0, outputs 0; after rst=1 bin_rdy_o=1.
//  2 60 bins all 16'h0800, bin_v_i continuous -> noteAmplitudes_o all 16'h2800,
//    start_o high 2 edges after last accept; data_v_i=1 in 3rd start cycle ->
//    start_o=0, bin_rdy_o=1, frame_cnt_o=1.
//  3 note 0 bins all 16'hFFFF in every octave, others 0 -> [0]=16'hFFFF, [1..11]=0.
//  4 data_v_i held 1 from frame start -> ignored in 1st start cycle, handoff after 2nd;
//    bin_v_i held 1 during WAIT -> no accepts, next frame still folds correctly.
//  5 30 bins of 16'h1000, flush_i, then 60 bins 16'h0800 -> all outputs 16'h2800.
//  6 bin_v_i toggled 1/0 each cycle, same data as 2 -> identical outputs, 2x duration.

Source files
------------

// File: rtl/note_octave_folder_if.sv
`default_nettype none
// ============================================================================
// Module      : note_octave_folder_if
// Description : Bin-stream input and note-amplitude handoff bundle for the
//               octave folder.
// Revision    : 1.0 - initial release
// ============================================================================
interface note_octave_folder_if #(
    parameter int W       = 5,
    parameter int D       = 11,
    parameter int BIN_QTY = 12
);
    logic [W+D-1:0]                bin_i;
    logic                          bin_v_i;
    logic                          bin_rdy_o;
    logic                          flush_i;
    logic [BIN_QTY-1:0][W+D-1:0]   noteAmplitudes_o;
    logic                          start_o;
    logic                          data_v_i;
    logic [7:0]                    frame_cnt_o;

    modport master (
        output bin_i, bin_v_i, flush_i, data_v_i,
        input  bin_rdy_o, noteAmplitudes_o, start_o, frame_cnt_o
    );

    modport slave (
        input  bin_i, bin_v_i, flush_i, data_v_i,
        output bin_rdy_o, noteAmplitudes_o, start_o, frame_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/note_octave_folder.sv
`default_nettype none
// ============================================================================
// Module      : note_octave_folder
// Description : Folds an octave-major DFT magnitude stream into BIN_QTY
//               saturated note amplitudes and hands them to the preprocessor.
// Revision    : 1.0 - initial release
// ============================================================================
module note_octave_folder #(
    parameter int W       = 5,
    parameter int D       = 11,
    parameter int BIN_QTY = 12,
    parameter int OCTAVES = 5
) (
    input  wire logic           clk,
    input  wire logic           rst,
    note_octave_folder_if.slave bus
);
    localparam int c_DW = W + D;
    localparam int c_AW = c_DW + $clog2(OCTAVES);
    localparam int c_NW = $clog2(BIN_QTY);
    localparam int c_OW = $clog2(OCTAVES);

    localparam logic [c_NW-1:0] c_NOTE_LAST = c_NW'(BIN_QTY - 1);
    localparam logic [c_OW-1:0] c_OCT_LAST  = c_OW'(OCTAVES - 1);

    localparam logic [1:0] c_ST_ACCUM = 2'd0;
    localparam logic [1:0] c_ST_XFER  = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;

    logic [1:0]                  r_state;
    logic [c_NW-1:0]             r_note;
    logic [c_OW-1:0]             r_oct;
    logic                        r_start;
    logic                        r_wait_first;
    logic [7:0]                  r_frame_cnt;
    logic [BIN_QTY-1:0][c_DW-1:0] r_notes;
    logic [c_DW-1:0]             w_sat [BIN_QTY];
    logic                        w_rdy;
    logic                        w_accept;

    assign w_rdy    = (r_state == c_ST_ACCUM) & rst;
    // A bin presented alongside flush belongs to the discarded frame.
    assign w_accept = bus.bin_v_i & w_rdy & ~bus.flush_i;

    assign bus.bin_rdy_o        = w_rdy;
    assign bus.start_o          = r_start;
    assign bus.frame_cnt_o      = r_frame_cnt;
    assign bus.noteAmplitudes_o = r_notes;

    genvar n;
    generate
        for (n = 0; n < BIN_QTY; n++) begin : g_note
            logic [c_AW-1:0] r_acc;

            // Octave 0 overwrites, so stale sums never need an explicit clear.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_acc <= '0;
                end else if (w_accept && (r_note == c_NW'(n))) begin
                    if (r_oct == '0)
                        r_acc <= c_AW'(bus.bin_i);
                    else
                        r_acc <= r_acc + c_AW'(bus.bin_i);
                end
            end

            assign w_sat[n] = (|r_acc[c_AW-1:c_DW]) ? {c_DW{1'b1}} : r_acc[c_DW-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= c_ST_ACCUM;
            r_note       <= '0;
            r_oct        <= '0;
            r_start      <= 1'b0;
            r_wait_first <= 1'b0;
            r_frame_cnt  <= '0;
            r_notes      <= '0;
        end else begin
            case (r_state)
                c_ST_ACCUM: begin
                    if (bus.flush_i) begin
                        r_note <= '0;
                        r_oct  <= '0;
                    end else if (w_accept) begin
                        if (r_note == c_NOTE_LAST) begin
                            r_note <= '0;
                            if (r_oct == c_OCT_LAST) begin
                                r_oct   <= '0;
                                r_state <= c_ST_XFER;
                            end else begin
                                r_oct <= r_oct + c_OW'(1);
                            end
                        end else begin
                            r_note <= r_note + c_NW'(1);
                        end
                    end
                end
                c_ST_XFER: begin
                    for (int i = 0; i < BIN_QTY; i++)
                        r_notes[i] <= w_sat[i];
                    r_start      <= 1'b1;
                    r_wait_first <= 1'b1;
                    r_state      <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    // First start cycle may still see the previous frame's done.
                    if (r_wait_first) begin
                        r_wait_first <= 1'b0;
                    end else if (bus.data_v_i) begin
                        r_start     <= 1'b0;
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                        r_state     <= c_ST_ACCUM;
                    end
                end
                default: r_state <= c_ST_ACCUM;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_note_octave_folder.sv
`default_nettype none
// ============================================================================
// Module      : tb_note_octave_folder
// Description : Directed self-checking bench for note_octave_folder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_note_octave_folder;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    note_octave_folder_if #(.W(5), .D(11), .BIN_QTY(12)) bus ();

    note_octave_folder #(.W(5), .D(11), .BIN_QTY(12), .OCTAVES(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bin i of the frame is note (i % 12); note 0 carries v0, the rest vo.
    task automatic send_bins(input int n, input logic [15:0] v0, input logic [15:0] vo,
                             input bit gap, output bit bad);
        bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.bin_i   = ((i % 12) == 0) ? v0 : vo;
            bus.bin_v_i = 1'b1;
            if (bus.bin_rdy_o !== 1'b1) bad = 1'b1;
            step();
            if (gap && i != n - 1) begin
                bus.bin_v_i = 1'b0;
                step();
            end
        end
        bus.bin_v_i = 1'b0;
    endtask

    task automatic handoff();
        step();
        step();
        bus.data_v_i = 1'b1;
        step();
        bus.data_v_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.bin_i = '0; bus.bin_v_i = 1'b0; bus.flush_i = 1'b0; bus.data_v_i = 1'b0;
        repeat (3) step();
        n_cmp++; if (bus.start_o !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b expected 0", bus.start_o); end
        n_cmp++; if (bus.bin_rdy_o !== 1'b0) begin n_bad++; $display("FAIL reset_rdy: got %b expected 0", bus.bin_rdy_o); end
        n_cmp++; if (bus.noteAmplitudes_o !== '0) begin n_bad++; $display("FAIL reset_notes: got %h expected 0", bus.noteAmplitudes_o); end
        n_cmp++; if (bus.frame_cnt_o !== 8'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d expected 0", bus.frame_cnt_o); end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.bin_rdy_o !== 1'b1) begin n_bad++; $display("FAIL release_rdy: got %b expected 1", bus.bin_rdy_o); end
    endtask

    task automatic test_fold_uniform();
        bit bad;
        send_bins(60, 16'h0800, 16'h0800, 1'b0, bad);
        n_cmp++; if (bad) begin n_bad++; $display("FAIL uni_rdy: got not-ready expected ready on every bin"); end
        n_cmp++; if (bus.start_o !== 1'b0) begin n_bad++; $display("FAIL uni_start_early: got %b expected 0", bus.start_o); end
        n_cmp++; if (bus.bin_rdy_o !== 1'b0) begin n_bad++; $display("FAIL uni_rdy_xfer: got %b expected 0", bus.bin_rdy_o); end
        step();
        n_cmp++; if (bus.start_o !== 1'b1) begin n_bad++; $display("FAIL uni_start: got %b expected 1", bus.start_o); end
        for (int k = 0; k < 12; k++) begin
            n_cmp++;
            if (bus.noteAmplitudes_o[k] !== 16'h2800) begin
                n_bad++; $display("FAIL uni_note%0d: got %h expected 2800", k, bus.noteAmplitudes_o[k]);
            end
        end
        step();
        step();
        n_cmp++; if (bus.start_o !== 1'b1) begin n_bad++; $display("FAIL uni_start_hold: got %b expected 1", bus.start_o); end
        bus.data_v_i = 1'b1;
        step();
        bus.data_v_i = 1'b0;
        n_cmp++; if (bus.start_o !== 1'b0) begin n_bad++; $display("FAIL uni_start_drop: got %b expected 0", bus.start_o); end
        n_cmp++; if (bus.bin_rdy_o !== 1'b1) begin n_bad++; $display("FAIL uni_rdy_back: got %b expected 1", bus.bin_rdy_o); end
        n_cmp++; if (bus.frame_cnt_o !== 8'd1) begin n_bad++; $display("FAIL uni_cnt: got %0d expected 1", bus.frame_cnt_o); end
        n_cmp++; if (bus.noteAmplitudes_o[5] !== 16'h2800) begin n_bad++; $display("FAIL uni_stable: got %h expected 2800", bus.noteAmplitudes_o[5]); end
    endtask

    task automatic test_saturate();
        bit bad;
        send_bins(60, 16'hFFFF, 16'h0000, 1'b0, bad);
        step();
        n_cmp++; if (bus.noteAmplitudes_o[0] !== 16'hFFFF) begin n_bad++; $display("FAIL sat_note0: got %h expected ffff", bus.noteAmplitudes_o[0]); end
        for (int k = 1; k < 12; k++) begin
            n_cmp++;
            if (bus.noteAmplitudes_o[k] !== 16'h0000) begin
                n_bad++; $display("FAIL sat_note%0d: got %h expected 0000", k, bus.noteAmplitudes_o[k]);
            end
        end
        handoff();
        n_cmp++; if (bus.frame_cnt_o !== 8'd2) begin n_bad++; $display("FAIL sat_cnt: got %0d expected 2", bus.frame_cnt_o); end
    endtask

    task automatic test_early_done();
        bit bad;
        bus.data_v_i = 1'b1;
        send_bins(60, 16'h0400, 16'h0400, 1'b0, bad);
        bus.bin_v_i = 1'b1;
        bus.bin_i   = 16'hFFFF;
        step();
        n_cmp++; if (bus.noteAmplitudes_o[3] !== 16'h1400) begin n_bad++; $display("FAIL early_note3: got %h expected 1400", bus.noteAmplitudes_o[3]); end
        step();
        n_cmp++; if (bus.start_o !== 1'b1) begin n_bad++; $display("FAIL early_ignored: got %b expected 1", bus.start_o); end
        step();
        n_cmp++; if (bus.start_o !== 1'b0) begin n_bad++; $display("FAIL early_drop: got %b expected 0", bus.start_o); end
        n_cmp++; if (bus.frame_cnt_o !== 8'd3) begin n_bad++; $display("FAIL early_cnt: got %0d expected 3", bus.frame_cnt_o); end
        bus.bin_v_i  = 1'b0;
        bus.data_v_i = 1'b0;
        send_bins(60, 16'h0800, 16'h0800, 1'b0, bad);
        step();
        for (int k = 0; k < 12; k++) begin
            n_cmp++;
            if (bus.noteAmplitudes_o[k] !== 16'h2800) begin
                n_bad++; $display("FAIL early_next_note%0d: got %h expected 2800", k, bus.noteAmplitudes_o[k]);
            end
        end
        handoff();
        n_cmp++; if (bus.frame_cnt_o !== 8'd4) begin n_bad++; $display("FAIL early_cnt2: got %0d expected 4", bus.frame_cnt_o); end
    endtask

    task automatic test_flush();
        bit bad;
        send_bins(30, 16'h1000, 16'h1000, 1'b0, bad);
        bus.flush_i = 1'b1;
        bus.bin_v_i = 1'b1;
        bus.bin_i   = 16'hFFFF;
        step();
        bus.flush_i = 1'b0;
        bus.bin_v_i = 1'b0;
        n_cmp++; if (bus.bin_rdy_o !== 1'b1) begin n_bad++; $display("FAIL flush_rdy: got %b expected 1", bus.bin_rdy_o); end
        send_bins(60, 16'h0800, 16'h0800, 1'b0, bad);
        n_cmp++; if (bus.start_o !== 1'b0) begin n_bad++; $display("FAIL flush_start_early: got %b expected 0", bus.start_o); end
        step();
        n_cmp++; if (bus.start_o !== 1'b1) begin n_bad++; $display("FAIL flush_start: got %b expected 1", bus.start_o); end
        for (int k = 0; k < 12; k++) begin
            n_cmp++;
            if (bus.noteAmplitudes_o[k] !== 16'h2800) begin
                n_bad++; $display("FAIL flush_note%0d: got %h expected 2800", k, bus.noteAmplitudes_o[k]);
            end
        end
        handoff();
        n_cmp++; if (bus.frame_cnt_o !== 8'd5) begin n_bad++; $display("FAIL flush_cnt: got %0d expected 5", bus.frame_cnt_o); end
    endtask

    task automatic test_toggle();
        bit bad;
        send_bins(60, 16'h0800, 16'h0800, 1'b1, bad);
        n_cmp++; if (bad) begin n_bad++; $display("FAIL tog_rdy: got not-ready expected ready on every bin"); end
        n_cmp++; if (bus.start_o !== 1'b0) begin n_bad++; $display("FAIL tog_start_early: got %b expected 0", bus.start_o); end
        step();
        n_cmp++; if (bus.start_o !== 1'b1) begin n_bad++; $display("FAIL tog_start: got %b expected 1", bus.start_o); end
        for (int k = 0; k < 12; k++) begin
            n_cmp++;
            if (bus.noteAmplitudes_o[k] !== 16'h2800) begin
                n_bad++; $display("FAIL tog_note%0d: got %h expected 2800", k, bus.noteAmplitudes_o[k]);
            end
        end
        handoff();
        n_cmp++; if (bus.frame_cnt_o !== 8'd6) begin n_bad++; $display("FAIL tog_cnt: got %0d expected 6", bus.frame_cnt_o); end
    endtask

    task automatic test_reset_in_wait();
        bit bad;
        send_bins(60, 16'h0800, 16'h0800, 1'b0, bad);
        step();
        rst = 1'b0;
        step();
        n_cmp++; if (bus.start_o !== 1'b0) begin n_bad++; $display("FAIL rstw_start: got %b expected 0", bus.start_o); end
        n_cmp++; if (bus.frame_cnt_o !== 8'd0) begin n_bad++; $display("FAIL rstw_cnt: got %0d expected 0", bus.frame_cnt_o); end
        n_cmp++; if (bus.noteAmplitudes_o !== '0) begin n_bad++; $display("FAIL rstw_notes: got %h expected 0", bus.noteAmplitudes_o); end
        n_cmp++; if (bus.bin_rdy_o !== 1'b0) begin n_bad++; $display("FAIL rstw_rdy: got %b expected 0", bus.bin_rdy_o); end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.bin_rdy_o !== 1'b1) begin n_bad++; $display("FAIL rstw_release: got %b expected 1", bus.bin_rdy_o); end
    endtask

    initial begin
        test_reset();
        test_fold_uniform();
        test_saturate();
        test_early_done();
        test_flush();
        test_toggle();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
